// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: two-requester arbiter that owns the select of a shared
// 2:1 datapath mux (y = s ? b : a) and presents the granted source on y.
// IDLE ties are round-robin by default. A holder is preempted after MAX_HOLD
// consecutive grant cycles, but only when the other side is requesting.
// Optional build macro: MUX_ARB_PRIO_EN -- IDLE ties always go to A. The hold
// timeout still applies, so B cannot be starved.
module mux_share_arbiter #(
   parameter int unsigned DW       = 1,
   parameter int unsigned MAX_HOLD = 500
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_a,
   input  logic          req_b,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic          gnt_a,
   output logic          gnt_b,
   output logic          s,
   output logic [DW-1:0] y,
   output logic          busy
);

   localparam int unsigned CntW = $clog2(MAX_HOLD);
   localparam logic [CntW-1:0] HoldMax = CntW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StGntA = 2'd1,
      StGntB = 2'd2
   } state_e;

   typedef enum logic {
      SideA = 1'b0,
      SideB = 1'b1
   } side_e;

   state_e          state_q, state_d;
   side_e           last_q, last_d;
   logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
   logic            s_q, s_d;
   state_e          tie_pick;
   logic            hold_expired;

   // IDLE tie resolution: fixed priority to A, or the side not served last
`ifdef MUX_ARB_PRIO_EN
   assign tie_pick = StGntA;
`else
   assign tie_pick = (last_q == SideA) ? StGntB : StGntA;
`endif

   assign hold_expired = (hold_cnt_q == HoldMax);

   // Next-state: release and handover take priority over preemption
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (req_a && req_b) begin
               state_d = tie_pick;
            end else if (req_a) begin
               state_d = StGntA;
            end else if (req_b) begin
               state_d = StGntB;
            end
         end
         StGntA: begin
            if (!req_a && req_b) begin
               state_d = StGntB;
            end else if (!req_a) begin
               state_d = StIdle;
            end else if (req_b && hold_expired) begin
               state_d = StGntB;
            end
         end
         StGntB: begin
            if (!req_b && req_a) begin
               state_d = StGntA;
            end else if (!req_b) begin
               state_d = StIdle;
            end else if (req_a && hold_expired) begin
               state_d = StGntA;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Hold counter: restarts on any state change, saturates while granted
   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (state_d != state_q) begin
         hold_cnt_d = '0;
      end else if ((state_q != StIdle) && !hold_expired) begin
         hold_cnt_d = hold_cnt_q + CntW'(1);
      end
   end

   // Select and last-served side follow grant entry; both hold in IDLE
   always_comb begin
      s_d    = s_q;
      last_d = last_q;
      if (state_d == StGntA) begin
         s_d    = 1'b0;
         last_d = SideA;
      end else if (state_d == StGntB) begin
         s_d    = 1'b1;
         last_d = SideB;
      end
   end

   // State registers with synchronous reset; last=B so A wins the first tie
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         last_q     <= SideB;
         hold_cnt_q <= '0;
         s_q        <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         s_q        <= s_d;
      end
   end

   // Output decode; y is forced to zero in IDLE so no stale data leaks out
   always_comb begin
      gnt_a = (state_q == StGntA);
      gnt_b = (state_q == StGntB);
      busy  = gnt_a | gnt_b;
      s     = s_q;
      y     = '0;
      case (state_q)
         StGntA:  y = a;
         StGntB:  y = b;
         default: y = '0;
      endcase
   end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Testbench for mux_share_arbiter (DW=4, MAX_HOLD=4). Expected observations
// are queued as stimulus is applied and popped after each clock edge.
module tb_mux_share_arbiter;

   localparam int unsigned DW       = 4;
   localparam int unsigned MAX_HOLD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_a;
   logic          req_b;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic          gnt_a;
   logic          gnt_b;
   logic          s;
   logic [DW-1:0] y;
   logic          busy;

   typedef struct packed {
      logic          ga;
      logic          gb;
      logic          sel;
      logic          bsy;
      logic [DW-1:0] yv;
   } obs_t;

   obs_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   mux_share_arbiter #(
      .DW      (DW),
      .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .req_a(req_a),
      .req_b(req_b),
      .a    (a),
      .b    (b),
      .gnt_a(gnt_a),
      .gnt_b(gnt_b),
      .s    (s),
      .y    (y),
      .busy (busy)
   );

   always #5 clk = ~clk;

   function automatic obs_t mk(logic ga, logic gb, logic sel, logic [DW-1:0] yv);
      obs_t o;
      o.ga  = ga;
      o.gb  = gb;
      o.sel = sel;
      o.bsy = ga | gb;
      o.yv  = yv;
      return o;
   endfunction

   function automatic obs_t seen();
      obs_t o;
      o.ga  = gnt_a;
      o.gb  = gnt_b;
      o.sel = s;
      o.bsy = busy;
      o.yv  = y;
      return o;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t e, o;
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = 4'h1; b = 4'h0;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0));
         tick();
         e = exp_q.pop_front(); o = seen(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL reset c%0d: got %b want %b", i, o, e);
         end
      end
   endtask

   task automatic test_single();
      obs_t e, o;
      rst = 1'b0; a = 4'h5; b = 4'hA;
      for (int i = 0; i < 6; i++) begin
         req_a = (i < 5);
         if (i < 5) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'h5));
         else       exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0));
         tick();
         e = exp_q.pop_front(); o = seen(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL single c%0d: got %b want %b", i, o, e);
         end
      end
   endtask

   task automatic test_no_contention();
      obs_t e, o;
      req_a = 1'b1; req_b = 1'b0; a = 4'h6;
      for (int i = 0; i < 20; i++) begin
         exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'h6));
         tick();
         e = exp_q.pop_front(); o = seen(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL nocont c%0d: got %b want %b", i, o, e);
         end
      end
      vectors++;
      if (dut.hold_cnt_q !== 2'd3) begin
         miscompares++;
         $display("FAIL hold_sat: got %0d want 3", dut.hold_cnt_q);
      end
      req_a = 1'b0;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0));
      tick();
      e = exp_q.pop_front(); o = seen(); vectors++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL nocont_rel: got %b want %b", o, e);
      end
   endtask

   // A was served last, so an IDLE tie goes to B unless fixed priority is built in
   task automatic test_tie_after_a();
      obs_t e, o;
      a = 4'h3; b = 4'hC;
      req_a = 1'b1; req_b = 1'b1;
`ifdef MUX_ARB_PRIO_EN
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'h3));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0));
`else
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 4'hC));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 4'h0));
`endif
      tick();
      e = exp_q.pop_front(); o = seen(); vectors++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL tie_last: got %b want %b", o, e);
      end
      req_a = 1'b0; req_b = 1'b0;
      tick();
      e = exp_q.pop_front(); o = seen(); vectors++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL tie_idle_s: got %b want %b", o, e);
      end
   endtask

   task automatic test_tie_preempt();
      obs_t e, o;
      logic ga;
      rst = 1'b1; req_a = 1'b1; req_b = 1'b1; a = 4'h3; b = 4'hC;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0));
      tick();
      e = exp_q.pop_front(); o = seen(); vectors++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL tie_rst: got %b want %b", o, e);
      end
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         ga = (k <= 4) || (k >= 9);
         exp_q.push_back(mk(ga, !ga, !ga, ga ? 4'h3 : 4'hC));
         tick();
         e = exp_q.pop_front(); o = seen(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL tie c%0d: got %b want %b", k, o, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t e, o;
      logic [1:0] reqs [6];
      reqs = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b00};  // {req_a, req_b}
      a = 4'h9; b = 4'h4;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 4'h4));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 4'h4));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'h9));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 4'h4));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 4'h0));
      for (int i = 0; i < 6; i++) begin
         req_a = reqs[i][1];
         req_b = reqs[i][0];
         tick();
         e = exp_q.pop_front(); o = seen(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL b2b c%0d: got %b want %b", i, o, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      obs_t e, o;
      a = 4'h7; b = 4'hE;
      req_a = 1'b0; req_b = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 4'hE));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'h7));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'h7));
      for (int i = 0; i < 6; i++) begin
         rst = (i == 3);
         if (i >= 3) req_a = 1'b1;
         tick();
         e = exp_q.pop_front(); o = seen(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL rstmid c%0d: got %b want %b", i, o, e);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0;
      test_reset();
      test_single();
      test_no_contention();
      test_tie_after_a();
      test_tie_preempt();
      test_back_to_back();
      test_reset_mid();
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard: got %0d left want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
